// File: rtl/dyn_partition_fixpoint_monitor.sv
// Reference-model checker for NCH dynamically partitioned W-bit counters. One observed
// transition is validated per handshake; the first divergence halts it and returns to the all-zero fixpoint are counted.
module dyn_partition_fixpoint_monitor #(
  parameter int NCH  = 2,
  parameter int W    = 3,
  parameter int SELW = 2,
  parameter int MODE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             obs_valid,
  output logic             obs_ready,
  input  logic [NCH*W-1:0] obs_cnt,
  input  logic [SELW-1:0]  obs_sel,
  output logic             chk_done,
  output logic             chk_ok,
  output logic             err_sticky,
  output logic [15:0]      err_index,
  output logic [15:0]      wrap_count
);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CHECK = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  // One extra bit so NCH == 2^SELW does not fold to zero.
  localparam logic [SELW:0] NCH_W = (SELW+1)'(NCH);

  state_t            state_r;
  state_t            next_state_s;
  logic              obs_ready_r;
  logic              chk_done_r;
  logic              chk_ok_r;
  logic              err_sticky_r;
  logic [15:0]       err_index_r;
  logic [15:0]       wrap_count_r;
  logic [15:0]       obs_idx_r;
  logic [NCH*W-1:0]  cap_cnt_r;
  logic [SELW-1:0]   cap_sel_r;
  logic              init_chk_r;
  logic [NCH*W-1:0]  model_cnt_r;
  logic [SELW-1:0]   model_sel_r;

  logic              accept_s;
  logic [NCH*W-1:0]  pred_cnt_s;
  logic [SELW-1:0]   pred_sel_s;
  logic              sel_bad_s;
  logic              match_s;
  logic              wrap_hit_s;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction

  assign accept_s = obs_valid & obs_ready_r;

  // Expected next state of the reference model for the captured observation.
  always_comb begin
    pred_cnt_s = model_cnt_r;
    pred_sel_s = model_sel_r;
    sel_bad_s  = 1'b0;
    if (init_chk_r) begin
      pred_cnt_s = '0;
      pred_sel_s = '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (model_sel_r == SELW'(i)) begin
          pred_cnt_s[i*W +: W] = model_cnt_r[i*W +: W] + W'(1);
        end else begin
          pred_cnt_s[i*W +: W] = model_cnt_r[i*W +: W];
        end
      end
      if (MODE == 0) begin
        if (model_sel_r == SELW'(NCH-1)) begin
          pred_sel_s = '0;
        end else begin
          pred_sel_s = model_sel_r + SELW'(1);
        end
      end else begin
        if ({1'b0, cap_sel_r} < NCH_W) begin
          pred_sel_s = cap_sel_r;
        end else begin
          pred_sel_s = model_sel_r;
          sel_bad_s  = 1'b1;
        end
      end
    end
  end

  // Compare capture against prediction and detect a return to the fixpoint.
  always_comb begin
    match_s    = !sel_bad_s && (cap_cnt_r == pred_cnt_s) && (cap_sel_r == pred_sel_s);
    wrap_hit_s = !init_chk_r && (pred_cnt_s == '0) && (pred_sel_s == '0);
  end

  // Next-state logic for the INIT/RUN/CHECK/HALT controller.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_INIT: begin
        if (accept_s) begin
          next_state_s = ST_CHECK;
        end else begin
          next_state_s = ST_INIT;
        end
      end
      ST_RUN: begin
        if (accept_s) begin
          next_state_s = ST_CHECK;
        end else begin
          next_state_s = ST_RUN;
        end
      end
      ST_CHECK: begin
        if (match_s) begin
          next_state_s = ST_RUN;
        end else begin
          next_state_s = ST_HALT;
        end
      end
      ST_HALT: next_state_s = ST_HALT;
      default: next_state_s = ST_HALT;
    endcase
  end

  // State register, capture, model update and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_INIT;
      obs_ready_r  <= 1'b0;
      chk_done_r   <= 1'b0;
      chk_ok_r     <= 1'b0;
      err_sticky_r <= 1'b0;
      err_index_r  <= 16'd0;
      wrap_count_r <= 16'd0;
      obs_idx_r    <= 16'd0;
      cap_cnt_r    <= '0;
      cap_sel_r    <= '0;
      init_chk_r   <= 1'b0;
      model_cnt_r  <= '0;
      model_sel_r  <= '0;
    end else begin
      state_r     <= next_state_s;
      obs_ready_r <= (next_state_s == ST_INIT) || (next_state_s == ST_RUN);
      chk_done_r  <= 1'b0;
      if (accept_s) begin
        cap_cnt_r  <= obs_cnt;
        cap_sel_r  <= obs_sel;
        init_chk_r <= (state_r == ST_INIT);
      end
      if (state_r == ST_CHECK) begin
        chk_done_r <= 1'b1;
        chk_ok_r   <= match_s;
        if (match_s) begin
          model_cnt_r <= pred_cnt_s;
          model_sel_r <= pred_sel_s;
          obs_idx_r   <= sat_inc16(obs_idx_r);
          if (wrap_hit_s) begin
            wrap_count_r <= sat_inc16(wrap_count_r);
          end
        end else begin
          err_sticky_r <= 1'b1;
          err_index_r  <= obs_idx_r;
        end
      end
    end
  end

  assign obs_ready  = obs_ready_r;
  assign chk_done   = chk_done_r;
  assign chk_ok     = chk_ok_r;
  assign err_sticky = err_sticky_r;
  assign err_index  = err_index_r;
  assign wrap_count = wrap_count_r;

endmodule

// File: tb/tb_dyn_partition_fixpoint_monitor.sv
// Randomized bench for dyn_partition_fixpoint_monitor: two instances (NCH=2,W=3,MODE=0 and
// NCH=3,W=1,MODE=1) checked against an array-based reference model of the counter rules.
module tb_dyn_partition_fixpoint_monitor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic v0 = 1'b0, v1 = 1'b0;
  logic [5:0] c0 = 6'd0;
  logic [2:0] c1 = 3'd0;
  logic [1:0] s0 = 2'd0, s1 = 2'd0;
  logic rdy0, done0, ok0, err0, rdy1, done1, ok1, err1;
  logic [15:0] eidx0, wrap0, eidx1, wrap1;

  int checks = 0;
  int errors = 0;

  int m_cnt[8];
  int m_sel, m_idx, m_wraps, m_erridx, m_nch, m_w, m_mode, cur;
  bit m_err, m_inited;

  always #5 clk = ~clk;

  dyn_partition_fixpoint_monitor #(.NCH(2), .W(3), .SELW(2), .MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .obs_valid(v0), .obs_ready(rdy0), .obs_cnt(c0), .obs_sel(s0),
    .chk_done(done0), .chk_ok(ok0), .err_sticky(err0), .err_index(eidx0), .wrap_count(wrap0));

  dyn_partition_fixpoint_monitor #(.NCH(3), .W(1), .SELW(2), .MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .obs_valid(v1), .obs_ready(rdy1), .obs_cnt(c1), .obs_sel(s1),
    .chk_done(done1), .chk_ok(ok1), .err_sticky(err1), .err_index(eidx1), .wrap_count(wrap1));

  function automatic logic get_rdy();
    if (cur == 0) return rdy0; else return rdy1;
  endfunction
  function automatic logic get_done();
    if (cur == 0) return done0; else return done1;
  endfunction
  function automatic logic get_ok();
    if (cur == 0) return ok0; else return ok1;
  endfunction
  function automatic logic get_err();
    if (cur == 0) return err0; else return err1;
  endfunction
  function automatic logic [15:0] get_eidx();
    if (cur == 0) return eidx0; else return eidx1;
  endfunction
  function automatic logic [15:0] get_wrap();
    if (cur == 0) return wrap0; else return wrap1;
  endfunction

  // Reference model: plain integer counters following the partition rules.
  task automatic model_reset(input int which);
    cur = which;
    m_nch = (which == 0) ? 2 : 3;
    m_w = (which == 0) ? 3 : 1;
    m_mode = (which == 0) ? 0 : 1;
    for (int i = 0; i < 8; i++) m_cnt[i] = 0;
    m_sel = 0; m_idx = 0; m_wraps = 0; m_erridx = 0; m_err = 1'b0; m_inited = 1'b0;
  endtask

  task automatic model_predict(output int pc[8], output int ps);
    pc = m_cnt;
    ps = 0;
    if (m_inited) begin
      pc[m_sel] = (pc[m_sel] + 1) % (1 << m_w);
      if (m_mode == 0) ps = (m_sel + 1) % m_nch;
      else ps = $urandom_range(m_nch - 1, 0);
    end
  endtask

  task automatic model_step(input int oc[8], input int os, output bit ok);
    int pc[8];
    int ps;
    bit zero;
    ok = 1'b1;
    if (!m_inited) begin
      for (int i = 0; i < m_nch; i++) if (oc[i] != 0) ok = 1'b0;
      if (os != 0) ok = 1'b0;
      if (ok) begin m_inited = 1'b1; m_idx = 1; end
    end else begin
      pc = m_cnt;
      pc[m_sel] = (pc[m_sel] + 1) % (1 << m_w);
      if (m_mode == 0) ps = (m_sel + 1) % m_nch;
      else if (os < m_nch) ps = os;
      else begin ps = -1; ok = 1'b0; end
      for (int i = 0; i < m_nch; i++) if (oc[i] != pc[i]) ok = 1'b0;
      if (os != ps) ok = 1'b0;
      if (ok) begin
        m_cnt = pc;
        m_sel = ps;
        zero = 1'b1;
        for (int i = 0; i < m_nch; i++) if (pc[i] != 0) zero = 1'b0;
        if (zero && ps == 0 && m_wraps < 65535) m_wraps++;
        if (m_idx < 65535) m_idx++;
      end
    end
    if (!ok) begin m_err = 1'b1; m_erridx = m_idx; end
  endtask

  task automatic drive(input bit v, input int oc[8], input int os);
    if (cur == 0) begin
      v0 = v;
      for (int i = 0; i < 2; i++) c0[i*3 +: 3] = 3'(oc[i]);
      s0 = 2'(os);
    end else begin
      v1 = v;
      for (int i = 0; i < 3; i++) c1[i] = 1'(oc[i]);
      s1 = 2'(os);
    end
  endtask

  // One handshake: wait for ready (bounded), transfer, observe CHECK cycle and result cycle.
  task automatic send(input int oc[8], input int os, input bit hold,
                      output bit acc, output logic mid_rdy, output logic mid_done,
                      output logic done, output logic ok);
    int n = 0;
    int g[8];
    acc = 1'b0; mid_rdy = 1'bx; mid_done = 1'bx; done = 1'b0; ok = 1'bx;
    while (get_rdy() !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    if (get_rdy() !== 1'b1) return;
    acc = 1'b1;
    drive(1'b1, oc, os);
    @(posedge clk); #1;
    if (hold) begin
      for (int i = 0; i < 8; i++) g[i] = int'($urandom);
      drive(1'b1, g, $urandom_range(3, 0));
    end else begin
      drive(1'b0, oc, os);
    end
    mid_rdy = get_rdy();
    mid_done = get_done();
    @(posedge clk); #1;
    drive(1'b0, oc, os);
    done = get_done();
    ok = get_ok();
  endtask

  task automatic do_reset();
    int z[8];
    for (int i = 0; i < 8; i++) z[i] = 0;
    cur = 0; drive(1'b0, z, 0);
    cur = 1; drive(1'b0, z, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Shared per-step scenario: send one observation, compare handshake and results with the model.
  task automatic run_step(input string tag, input int k, input int oc[8], input int os);
    bit acc, eok;
    logic mr, md, d, ok;
    send(oc, os, 1'($urandom_range(1, 0)), acc, mr, md, d, ok);
    model_step(oc, os, eok);
    checks++;
    if (!acc || mr !== 1'b0 || md !== 1'b0 || d !== 1'b1 || ok !== eok) begin
      errors++;
      $display("FAIL %s[%0d] acc=%0d rdy_mid=%b done_mid=%b done=%b ok=%b required 1 0 0 1 %b",
               tag, k, acc, mr, md, d, ok, eok);
    end
    checks++;
    if (get_err() !== m_err || get_eidx() !== 16'(m_erridx) || get_wrap() !== 16'(m_wraps)) begin
      errors++;
      $display("FAIL %s_status[%0d] err=%b idx=%0d wrap=%0d required %b %0d %0d",
               tag, k, get_err(), get_eidx(), get_wrap(), m_err, m_erridx, m_wraps);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({rdy0, done0, ok0, err0, eidx0, wrap0} !== 36'd0 || {rdy1, done1, ok1, err1, eidx1, wrap1} !== 36'd0) begin
      errors++;
      $display("FAIL reset_values dut0=%b/%b/%b/%b/%0d/%0d dut1=%b/%b/%b/%b/%0d/%0d required all 0",
               rdy0, done0, ok0, err0, eidx0, wrap0, rdy1, done1, ok1, err1, eidx1, wrap1);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (rdy0 !== 1'b0) begin errors++; $display("FAIL ready_before_edge got %b required 0", rdy0); end
    @(posedge clk); #1;
    checks++;
    if (rdy0 !== 1'b1 || rdy1 !== 1'b1) begin
      errors++; $display("FAIL ready_after_release got %b %b required 1 1", rdy0, rdy1);
    end
  endtask

  task automatic test_legal_stream();
    int pc[8];
    int ps;
    int z[8];
    do_reset();
    model_reset(0);
    for (int i = 0; i < 8; i++) z[i] = 0;
    run_step("init_zero", 0, z, 0);
    for (int k = 1; k <= 16; k++) begin
      repeat ($urandom_range(2, 0)) begin
        for (int i = 0; i < 8; i++) z[i] = int'($urandom);
        drive(1'b0, z, $urandom_range(3, 0));
        @(posedge clk); #1;
      end
      model_predict(pc, ps);
      run_step("legal", k, pc, ps);
    end
    checks++;
    if (wrap0 !== 16'd1 || err0 !== 1'b0) begin
      errors++; $display("FAIL legal_wrap wrap=%0d err=%b required 1 0", wrap0, err0);
    end
  endtask

  task automatic test_inject_error();
    int pc[8];
    int ps;
    int z[8];
    do_reset();
    model_reset(0);
    for (int i = 0; i < 8; i++) z[i] = 0;
    run_step("inj_init", 0, z, 0);
    for (int k = 1; k <= 4; k++) begin
      model_predict(pc, ps);
      run_step("inj_pre", k, pc, ps);
    end
    pc = m_cnt;
    pc[1] = (pc[1] + 1) % 8;
    run_step("inj_bad", 5, pc, 1);
    checks++;
    if (ok0 !== 1'b0 || err0 !== 1'b1 || eidx0 !== 16'd5) begin
      errors++; $display("FAIL inject_result ok=%b err=%b idx=%0d required 0 1 5", ok0, err0, eidx0);
    end
    for (int i = 0; i < 8; i++) z[i] = 0;
    drive(1'b1, z, 0);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      checks++;
      if (rdy0 !== 1'b0 || done0 !== 1'b0 || eidx0 !== 16'd5) begin
        errors++; $display("FAIL halt_hold[%0d] ready=%b done=%b idx=%0d required 0 0 5", c, rdy0, done0, eidx0);
      end
    end
    drive(1'b0, z, 0);
  endtask

  task automatic test_bad_init();
    int z[8];
    do_reset();
    model_reset(0);
    for (int i = 0; i < 8; i++) z[i] = 0;
    z[0] = 1;
    run_step("bad_init", 0, z, 0);
    @(posedge clk); #1;
    checks++;
    if (err0 !== 1'b1 || eidx0 !== 16'd0 || rdy0 !== 1'b0 || ok0 !== 1'b0) begin
      errors++; $display("FAIL bad_init_halt err=%b idx=%0d ready=%b ok=%b required 1 0 0 0", err0, eidx0, rdy0, ok0);
    end
  endtask

  task automatic test_mode1();
    int pc[8];
    int ps;
    int z[8];
    do_reset();
    model_reset(1);
    for (int i = 0; i < 8; i++) z[i] = 0;
    run_step("m1_init", 0, z, 0);
    model_predict(pc, ps);
    run_step("m1_sel3", 1, pc, 3);
    checks++;
    if (ok1 !== 1'b0 || err1 !== 1'b1 || eidx1 !== 16'd1) begin
      errors++; $display("FAIL mode1_sel3 ok=%b err=%b idx=%0d required 0 1 1", ok1, err1, eidx1);
    end
    do_reset();
    model_reset(1);
    run_step("m1_init2", 0, z, 0);
    z[0] = 1;
    run_step("m1_sel2", 1, z, 2);
    z[2] = 1;
    run_step("m1_use2", 2, z, 0);
    checks++;
    if (ok1 !== 1'b1 || err1 !== 1'b0) begin
      errors++; $display("FAIL mode1_sel2_used ok=%b err=%b required 1 0", ok1, err1);
    end
    for (int k = 3; k < 23; k++) begin
      model_predict(pc, ps);
      run_step("m1_rand", k, pc, ps);
    end
  endtask

  task automatic test_reset_mid_check();
    int pc[8];
    int ps;
    int z[8];
    do_reset();
    model_reset(0);
    for (int i = 0; i < 8; i++) z[i] = 0;
    run_step("mid_init", 0, z, 0);
    model_predict(pc, ps);
    drive(1'b1, pc, ps);
    @(posedge clk); #1;
    drive(1'b0, pc, ps);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({rdy0, done0, ok0, err0, eidx0, wrap0} !== 36'd0) begin
      errors++; $display("FAIL mid_check_reset ready=%b done=%b ok=%b err=%b idx=%0d wrap=%0d required all 0",
                         rdy0, done0, ok0, err0, eidx0, wrap0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (done0 !== 1'b0 || rdy0 !== 1'b1) begin
      errors++; $display("FAIL mid_check_after done=%b ready=%b required 0 1", done0, rdy0);
    end
    model_reset(0);
    run_step("mid_fresh_init", 0, z, 0);
  endtask

  task automatic test_back_to_back();
    int pc[8];
    int ps;
    int z[8];
    for (int run = 0; run < 6; run++) begin
      do_reset();
      model_reset(run % 2);
      for (int i = 0; i < 8; i++) z[i] = 0;
      run_step("b2b_init", run, z, 0);
      for (int k = 1; k <= 30 && !m_err; k++) begin
        model_predict(pc, ps);
        if ($urandom_range(11, 0) == 0) begin
          if ($urandom_range(1, 0) == 0) pc[$urandom_range(m_nch - 1, 0)] ^= (1 << $urandom_range(m_w - 1, 0));
          else if (m_mode == 0) ps = (ps + 1) % m_nch;
          else ps = 3;
        end
        run_step("b2b", run * 100 + k, pc, ps);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    #1;
    test_reset();
    test_legal_stream();
    test_inject_error();
    test_bad_init();
    test_mode1();
    test_reset_mid_check();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
